// File: rtl/riscv_wb_arbiter.sv
// Write-back arbiter: merges EX, LSU and buffered APU results onto the register file's two
// write ports, and flags source registers whose write has not yet landed.
module riscv_wb_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 6,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned APU_FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  ex_valid_i,
  input  logic [ADDR_WIDTH-1:0] ex_waddr_i,
  input  logic [DATA_WIDTH-1:0] ex_wdata_i,

  input  logic                  lsu_valid_i,
  input  logic [ADDR_WIDTH-1:0] lsu_waddr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,

  input  logic                  apu_valid_i,
  output logic                  apu_ready_o,
  input  logic [ADDR_WIDTH-1:0] apu_waddr_i,
  input  logic [DATA_WIDTH-1:0] apu_wdata_i,

  output logic [ADDR_WIDTH-1:0] waddr_a_o,
  output logic [DATA_WIDTH-1:0] wdata_a_o,
  output logic                  we_a_o,

  output logic [ADDR_WIDTH-1:0] waddr_b_o,
  output logic [DATA_WIDTH-1:0] wdata_b_o,
  output logic                  we_b_o,

  input  logic [ADDR_WIDTH-1:0] hazard_raddr_i,
  output logic                  hazard_o,
  output logic                  apu_fifo_empty_o
);

  localparam int unsigned PtrW = $clog2(APU_FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(APU_FIFO_DEPTH);

  if (APU_FIFO_DEPTH < 2 || (APU_FIFO_DEPTH & (APU_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("APU_FIFO_DEPTH must be a power of two and at least 2");
  end

  // APU result buffer
  logic [ADDR_WIDTH-1:0] r_fifo_addr [APU_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_fifo_data [APU_FIFO_DEPTH];
  logic [PtrW-1:0]       r_rd_ptr;
  logic [PtrW-1:0]       r_wr_ptr;
  logic [CntW-1:0]       r_count;

  // Registered write ports
  logic                  r_we_a;
  logic [ADDR_WIDTH-1:0] r_waddr_a;
  logic [DATA_WIDTH-1:0] r_wdata_a;
  logic                  r_we_b;
  logic [ADDR_WIDTH-1:0] r_waddr_b;
  logic [DATA_WIDTH-1:0] r_wdata_b;

  logic                  w_head_valid;
  logic                  w_pop_a;
  logic                  w_pop_b;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_apu_ready;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic                  w_fifo_hit;
  logic [PtrW-1:0]       w_scan_idx;

  assign w_head_valid = (r_count != '0);
  assign w_head_addr  = r_fifo_addr[r_rd_ptr];
  assign w_head_data  = r_fifo_data[r_rd_ptr];

  // Port B is preferred for draining; port A only takes the head when LSU owns port B.
  assign w_pop_b = w_head_valid && !lsu_valid_i;
  assign w_pop_a = w_head_valid && lsu_valid_i && !ex_valid_i;
  assign w_pop   = w_pop_a || w_pop_b;

  // Ready depends on registered occupancy only; x0 results are accepted but dropped.
  assign w_apu_ready = (r_count != FullCnt);
  assign w_push      = apu_valid_i && w_apu_ready && (apu_waddr_i != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= apu_waddr_i;
      r_fifo_data[r_wr_ptr] <= apu_wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we_a    <= 1'b0;
      r_waddr_a <= '0;
      r_wdata_a <= '0;
      r_we_b    <= 1'b0;
      r_waddr_b <= '0;
      r_wdata_b <= '0;
    end else begin
      if (ex_valid_i) begin
        r_we_a    <= (ex_waddr_i != '0);
        r_waddr_a <= ex_waddr_i;
        r_wdata_a <= ex_wdata_i;
      end else if (w_pop_a) begin
        r_we_a    <= 1'b1;
        r_waddr_a <= w_head_addr;
        r_wdata_a <= w_head_data;
      end else begin
        r_we_a    <= 1'b0;
      end

      if (lsu_valid_i) begin
        r_we_b    <= (lsu_waddr_i != '0);
        r_waddr_b <= lsu_waddr_i;
        r_wdata_b <= lsu_wdata_i;
      end else if (w_pop_b) begin
        r_we_b    <= 1'b1;
        r_waddr_b <= w_head_addr;
        r_wdata_b <= w_head_data;
      end else begin
        r_we_b    <= 1'b0;
      end
    end
  end

  // Scan only the occupied slots, starting from the read pointer.
  always_comb begin
    w_fifo_hit = 1'b0;
    w_scan_idx = '0;
    for (int unsigned i = 0; i < APU_FIFO_DEPTH; i++) begin
      w_scan_idx = r_rd_ptr + PtrW'(i);
      if ((CntW'(i) < r_count) && (r_fifo_addr[w_scan_idx] == hazard_raddr_i)) begin
        w_fifo_hit = 1'b1;
      end
    end
  end

  assign hazard_o = (hazard_raddr_i != '0) &&
                    (w_fifo_hit ||
                     (r_we_a && (r_waddr_a == hazard_raddr_i)) ||
                     (r_we_b && (r_waddr_b == hazard_raddr_i)));

  assign apu_ready_o      = w_apu_ready;
  assign apu_fifo_empty_o = !w_head_valid;

  assign we_a_o    = r_we_a;
  assign waddr_a_o = r_waddr_a;
  assign wdata_a_o = r_wdata_a;
  assign we_b_o    = r_we_b;
  assign waddr_b_o = r_waddr_b;
  assign wdata_b_o = r_wdata_b;

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Directed self-checking bench for riscv_wb_arbiter with hand-computed expectations.
module tb_riscv_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ex_valid_i;
  logic [5:0]  ex_waddr_i;
  logic [31:0] ex_wdata_i;
  logic        lsu_valid_i;
  logic [5:0]  lsu_waddr_i;
  logic [31:0] lsu_wdata_i;
  logic        apu_valid_i;
  logic        apu_ready_o;
  logic [5:0]  apu_waddr_i;
  logic [31:0] apu_wdata_i;
  logic [5:0]  waddr_a_o;
  logic [31:0] wdata_a_o;
  logic        we_a_o;
  logic [5:0]  waddr_b_o;
  logic [31:0] wdata_b_o;
  logic        we_b_o;
  logic [5:0]  hazard_raddr_i;
  logic        hazard_o;
  logic        apu_fifo_empty_o;

  int checks = 0;
  int errors = 0;

  riscv_wb_arbiter #(
    .ADDR_WIDTH     (6),
    .DATA_WIDTH     (32),
    .APU_FIFO_DEPTH (2)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ex_valid_i       (ex_valid_i),
    .ex_waddr_i       (ex_waddr_i),
    .ex_wdata_i       (ex_wdata_i),
    .lsu_valid_i      (lsu_valid_i),
    .lsu_waddr_i      (lsu_waddr_i),
    .lsu_wdata_i      (lsu_wdata_i),
    .apu_valid_i      (apu_valid_i),
    .apu_ready_o      (apu_ready_o),
    .apu_waddr_i      (apu_waddr_i),
    .apu_wdata_i      (apu_wdata_i),
    .waddr_a_o        (waddr_a_o),
    .wdata_a_o        (wdata_a_o),
    .we_a_o           (we_a_o),
    .waddr_b_o        (waddr_b_o),
    .wdata_b_o        (wdata_b_o),
    .we_b_o           (we_b_o),
    .hazard_raddr_i   (hazard_raddr_i),
    .hazard_o         (hazard_o),
    .apu_fifo_empty_o (apu_fifo_empty_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next active edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid_i  = 1'b0; ex_waddr_i  = '0; ex_wdata_i  = '0;
    lsu_valid_i = 1'b0; lsu_waddr_i = '0; lsu_wdata_i = '0;
    apu_valid_i = 1'b0; apu_waddr_i = '0; apu_wdata_i = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    hazard_raddr_i = 6'd5;
    rst_n = 1'b0;
    #2;
    checks++; if (we_a_o !== 1'b0) begin errors++;
      $display("FAIL reset_we_a: got %b want 0", we_a_o); end
    checks++; if (we_b_o !== 1'b0) begin errors++;
      $display("FAIL reset_we_b: got %b want 0", we_b_o); end
    checks++; if (waddr_a_o !== 6'd0 || wdata_a_o !== 32'd0) begin errors++;
      $display("FAIL reset_port_a: got %0d/%h want 0/0", waddr_a_o, wdata_a_o); end
    checks++; if (waddr_b_o !== 6'd0 || wdata_b_o !== 32'd0) begin errors++;
      $display("FAIL reset_port_b: got %0d/%h want 0/0", waddr_b_o, wdata_b_o); end
    checks++; if (apu_ready_o !== 1'b1 || apu_fifo_empty_o !== 1'b1) begin errors++;
      $display("FAIL reset_fifo: ready=%b empty=%b want 1/1", apu_ready_o, apu_fifo_empty_o); end
    checks++; if (hazard_o !== 1'b0) begin errors++;
      $display("FAIL reset_hazard: got %b want 0", hazard_o); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_stream();
    ex_valid_i  = 1'b1; ex_waddr_i  = 6'd5; ex_wdata_i  = 32'hDEADBEEF;
    lsu_valid_i = 1'b1; lsu_waddr_i = 6'd6; lsu_wdata_i = 32'h12345678;
    tick();
    idle_inputs();
    checks++; if (we_a_o !== 1'b1 || waddr_a_o !== 6'd5 || wdata_a_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_port_a: got we=%b %0d %h want 1 5 deadbeef",
               we_a_o, waddr_a_o, wdata_a_o); end
    checks++; if (we_b_o !== 1'b1 || waddr_b_o !== 6'd6 || wdata_b_o !== 32'h12345678) begin
      errors++;
      $display("FAIL single_port_b: got we=%b %0d %h want 1 6 12345678",
               we_b_o, waddr_b_o, wdata_b_o); end
    hazard_raddr_i = 6'd6;
    #1;
    checks++; if (hazard_o !== 1'b1) begin errors++;
      $display("FAIL single_hazard_inflight: got %b want 1", hazard_o); end
    tick();
    checks++; if (we_a_o !== 1'b0 || we_b_o !== 1'b0) begin errors++;
      $display("FAIL single_we_clear: got a=%b b=%b want 0 0", we_a_o, we_b_o); end
    checks++; if (hazard_o !== 1'b0) begin errors++;
      $display("FAIL single_hazard_clear: got %b want 0", hazard_o); end
  endtask

  task automatic test_apu_drain();
    hazard_raddr_i = 6'd7;
    apu_valid_i = 1'b1; apu_waddr_i = 6'd7; apu_wdata_i = 32'hA5A5A5A5;
    checks++; if (apu_ready_o !== 1'b1) begin errors++;
      $display("FAIL drain_ready: got %b want 1", apu_ready_o); end
    tick();
    idle_inputs();
    checks++; if (hazard_o !== 1'b1 || apu_fifo_empty_o !== 1'b0 || we_b_o !== 1'b0) begin
      errors++;
      $display("FAIL drain_t1: got hazard=%b empty=%b we_b=%b want 1 0 0",
               hazard_o, apu_fifo_empty_o, we_b_o); end
    tick();
    checks++; if (we_b_o !== 1'b1 || waddr_b_o !== 6'd7 || wdata_b_o !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL drain_t2_port_b: got we=%b %0d %h want 1 7 a5a5a5a5",
               we_b_o, waddr_b_o, wdata_b_o); end
    checks++; if (hazard_o !== 1'b1 || we_a_o !== 1'b0) begin errors++;
      $display("FAIL drain_t2_hazard: got hazard=%b we_a=%b want 1 0", hazard_o, we_a_o); end
    tick();
    checks++; if (hazard_o !== 1'b0 || we_b_o !== 1'b0) begin errors++;
      $display("FAIL drain_t3: got hazard=%b we_b=%b want 0 0", hazard_o, we_b_o); end
  endtask

  task automatic test_full_fifo();
    ex_valid_i  = 1'b1; ex_waddr_i  = 6'd1; ex_wdata_i  = 32'h1111;
    lsu_valid_i = 1'b1; lsu_waddr_i = 6'd2; lsu_wdata_i = 32'h2222;
    apu_valid_i = 1'b1; apu_waddr_i = 6'd10; apu_wdata_i = 32'h100;
    tick();
    apu_waddr_i = 6'd11; apu_wdata_i = 32'h101;
    checks++; if (apu_ready_o !== 1'b1) begin errors++;
      $display("FAIL full_second_ready: got %b want 1", apu_ready_o); end
    tick();
    apu_waddr_i = 6'd12; apu_wdata_i = 32'h102;
    checks++; if (apu_ready_o !== 1'b0) begin errors++;
      $display("FAIL full_third_blocked: got %b want 0", apu_ready_o); end
    tick();
    hazard_raddr_i = 6'd11;
    #1;
    checks++; if (apu_ready_o !== 1'b0 || hazard_o !== 1'b1 || we_a_o !== 1'b1 ||
                  waddr_a_o !== 6'd1 || we_b_o !== 1'b1 || waddr_b_o !== 6'd2) begin
      errors++;
      $display("FAIL full_hold: got ready=%b hazard=%b a=%b/%0d b=%b/%0d want 0 1 1/1 1/2",
               apu_ready_o, hazard_o, we_a_o, waddr_a_o, we_b_o, waddr_b_o); end
    ex_valid_i = 1'b0;
    tick();
    checks++; if (we_a_o !== 1'b1 || waddr_a_o !== 6'd10 || wdata_a_o !== 32'h100) begin
      errors++;
      $display("FAIL full_pop0: got we=%b %0d %h want 1 10 100", we_a_o, waddr_a_o, wdata_a_o);
    end
    checks++; if (apu_ready_o !== 1'b1) begin errors++;
      $display("FAIL full_ready_return: got %b want 1", apu_ready_o); end
    tick();
    apu_valid_i = 1'b0;
    checks++; if (we_a_o !== 1'b1 || waddr_a_o !== 6'd11 || wdata_a_o !== 32'h101) begin
      errors++;
      $display("FAIL full_pop1: got we=%b %0d %h want 1 11 101", we_a_o, waddr_a_o, wdata_a_o);
    end
    tick();
    checks++; if (we_a_o !== 1'b1 || waddr_a_o !== 6'd12 || wdata_a_o !== 32'h102) begin
      errors++;
      $display("FAIL full_pop2: got we=%b %0d %h want 1 12 102", we_a_o, waddr_a_o, wdata_a_o);
    end
    tick();
    idle_inputs();
    checks++; if (we_a_o !== 1'b0 || apu_fifo_empty_o !== 1'b1) begin errors++;
      $display("FAIL full_done: got we_a=%b empty=%b want 0 1", we_a_o, apu_fifo_empty_o); end
    tick();
  endtask

  task automatic test_addr_zero();
    hazard_raddr_i = 6'd0;
    ex_valid_i  = 1'b1; ex_waddr_i  = 6'd0; ex_wdata_i  = 32'hFFFFFFFF;
    lsu_valid_i = 1'b1; lsu_waddr_i = 6'd0; lsu_wdata_i = 32'hFFFFFFFF;
    apu_valid_i = 1'b1; apu_waddr_i = 6'd0; apu_wdata_i = 32'hFFFFFFFF;
    checks++; if (apu_ready_o !== 1'b1) begin errors++;
      $display("FAIL zero_handshake: got ready=%b want 1", apu_ready_o); end
    tick();
    idle_inputs();
    checks++; if (we_a_o !== 1'b0 || we_b_o !== 1'b0) begin errors++;
      $display("FAIL zero_we: got a=%b b=%b want 0 0", we_a_o, we_b_o); end
    checks++; if (apu_fifo_empty_o !== 1'b1 || hazard_o !== 1'b0) begin errors++;
      $display("FAIL zero_fifo: got empty=%b hazard=%b want 1 0", apu_fifo_empty_o, hazard_o);
    end
    tick();
    checks++; if (we_a_o !== 1'b0 || we_b_o !== 1'b0 || apu_fifo_empty_o !== 1'b1) begin
      errors++;
      $display("FAIL zero_after: got a=%b b=%b empty=%b want 0 0 1",
               we_a_o, we_b_o, apu_fifo_empty_o); end
  endtask

  task automatic test_reset_mid();
    ex_valid_i  = 1'b1; ex_waddr_i  = 6'd3; ex_wdata_i  = 32'h33;
    lsu_valid_i = 1'b1; lsu_waddr_i = 6'd4; lsu_wdata_i = 32'h44;
    apu_valid_i = 1'b1; apu_waddr_i = 6'd20; apu_wdata_i = 32'h200;
    tick();
    apu_waddr_i = 6'd21; apu_wdata_i = 32'h201;
    tick();
    apu_valid_i = 1'b0;
    hazard_raddr_i = 6'd20;
    #1;
    checks++; if (apu_fifo_empty_o !== 1'b0 || apu_ready_o !== 1'b0 || hazard_o !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: got empty=%b ready=%b hazard=%b want 0 0 1",
               apu_fifo_empty_o, apu_ready_o, hazard_o); end
    rst_n = 1'b0;
    #1;
    checks++; if (we_a_o !== 1'b0 || we_b_o !== 1'b0) begin errors++;
      $display("FAIL rstmid_we: got a=%b b=%b want 0 0", we_a_o, we_b_o); end
    checks++; if (apu_ready_o !== 1'b1 || apu_fifo_empty_o !== 1'b1 || hazard_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_state: got ready=%b empty=%b hazard=%b want 1 1 0",
               apu_ready_o, apu_fifo_empty_o, hazard_o); end
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (we_a_o !== 1'b0 || we_b_o !== 1'b0 || apu_fifo_empty_o !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_stale cycle %0d: got a=%b b=%b empty=%b want 0 0 1",
                 c, we_a_o, we_b_o, apu_fifo_empty_o); end
    end
  endtask

  task automatic test_pointer_wrap();
    int nwrites;
    logic [5:0]  exp_addr;
    logic [31:0] exp_data;
    nwrites = 0;
    hazard_raddr_i = 6'd0;
    for (int c = 0; c < 14; c++) begin
      if (c < 10) begin
        apu_valid_i = 1'b1;
        apu_waddr_i = 6'(c + 1);
        apu_wdata_i = 32'hC0DE0000 + 32'(c);
        checks++; if (apu_ready_o !== 1'b1) begin errors++;
          $display("FAIL wrap_ready cycle %0d: got %b want 1", c, apu_ready_o); end
      end else begin
        apu_valid_i = 1'b0;
      end
      tick();
      if (we_a_o !== 1'b0) begin
        checks++; errors++;
        $display("FAIL wrap_port_a cycle %0d: got we_a=1 want 0", c);
      end
      if (we_b_o === 1'b1) begin
        exp_addr = 6'(nwrites + 1);
        exp_data = 32'hC0DE0000 + 32'(nwrites);
        checks++; if (waddr_b_o !== exp_addr || wdata_b_o !== exp_data) begin errors++;
          $display("FAIL wrap_order write %0d: got %0d %h want %0d %h",
                   nwrites, waddr_b_o, wdata_b_o, exp_addr, exp_data); end
        nwrites++;
      end
    end
    idle_inputs();
    checks++; if (nwrites != 10) begin errors++;
      $display("FAIL wrap_count: got %0d writes want 10", nwrites); end
    checks++; if (apu_fifo_empty_o !== 1'b1) begin errors++;
      $display("FAIL wrap_empty: got %b want 1", apu_fifo_empty_o); end
  endtask

  initial begin
    idle_inputs();
    hazard_raddr_i = '0;
    rst_n = 1'b0;
    test_reset();
    test_single_stream();
    test_apu_drain();
    test_full_fifo();
    test_addr_zero();
    test_reset_mid();
    test_pointer_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_wb_arbiter.md
# riscv_wb_arbiter

Write-back arbiter between the execution units and the register file's two write ports (W1 = port A, W2 = port B). It merges three result streams: EX (single-cycle ALU), LSU (load return) and APU (long-latency, back-pressured). The non-stallable EX and LSU results get a fixed port each. APU results are buffered in a small FIFO and drained into whichever port is idle. A hazard output tells the decoder when a source register still has a write in flight, so operand reads stall until the value has landed.

## Interface
- ADDR_WIDTH, 6, register address width (bit 5 selects the FP bank when FPU=1).
- DATA_WIDTH, 32, result width.
- APU_FIFO_DEPTH, 2, APU result buffer entries; power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ex_valid_i  in  1  EX result valid; always accepted, no ready.
- ex_waddr_i  in  ADDR_WIDTH  EX destination.
- ex_wdata_i  in  DATA_WIDTH  EX result.
- lsu_valid_i  in  1  load data valid; always accepted, no ready.
- lsu_waddr_i  in  ADDR_WIDTH  load destination.
- lsu_wdata_i  in  DATA_WIDTH  load data.
- apu_valid_i  in  1  APU result valid.
- apu_ready_o  out  1  FIFO can accept an APU result.
- apu_waddr_i  in  ADDR_WIDTH  APU destination.
- apu_wdata_i  in  DATA_WIDTH  APU result.
- waddr_a_o, wdata_a_o, we_a_o  out  ADDR_WIDTH/DATA_WIDTH/1  register file write port A.
- waddr_b_o, wdata_b_o, we_b_o  out  ADDR_WIDTH/DATA_WIDTH/1  register file write port B.
- hazard_raddr_i  in  ADDR_WIDTH  address queried by the decoder.
- hazard_o  out  1  a write to hazard_raddr_i is pending.
- apu_fifo_empty_o  out  1  FIFO holds no entries.

## Operation
- All write-port outputs are registered. Reset values: all we 0, all waddr 0, all wdata 0.
- apu_ready_o resets to 1; apu_fifo_empty_o resets to 1; hazard_o is 0 after reset.
- Port A source: EX if ex_valid_i, else the FIFO head if it is not taken by port B, else idle.
- Port B source: LSU if lsu_valid_i, else the FIFO head, else idle.
- Pop rule: at most one FIFO pop per cycle, preferring port B.
  - Head drains to port B when lsu_valid_i=0.
  - Otherwise head drains to port A when ex_valid_i=0.
  - Otherwise the head stays.
- Address 0 handling:
  - An EX or LSU write to address 0 drives we=0 for that cycle.
  - An APU handshake to address 0 completes (is accepted) but pushes nothing.
- Same-address EX and LSU in the same cycle: both ports are written. The register file gives port B priority, so the LSU value wins. This is by design.
- FIFO behaviour:
  - Circular buffer with read and write pointers wrapping at APU_FIFO_DEPTH, plus an occupancy counter of width clog2(DEPTH)+1.
  - Push when apu_valid_i && apu_ready_o.
  - apu_ready_o = (count != DEPTH), derived from registered state only; there is no full-bypass.
  - Push and pop in the same cycle leave count unchanged.
  - No bypass path: an APU result always spends at least one cycle in the FIFO.
- hazard_o is 1 when hazard_raddr_i != 0 and it matches either of:
  - any valid FIFO entry;
  - a registered output stage with we=1 (data not yet in the register file).
- hazard_o is combinational from the query input and registered state.

## Timing
- EX/LSU: result on inputs in cycle t → we_x_o=1 in cycle t+1 → register file updated at the edge ending t+1.
- APU: handshake in cycle t → entry visible at the head in t+1 → earliest we in t+2.
- APU ordering: FIFO order is preserved. If both ports are busy for N cycles, the APU write is delayed by N.
- Reset mid-operation: FIFO contents are discarded, count=0, all we deasserted immediately (asynchronous), apu_ready_o=1.
- Back-pressure: a full FIFO with continuous EX and LSU traffic holds apu_ready_o=0 indefinitely. This is legal; the APU must hold valid/addr/data until ready.

## Test plan
- Single-stream writes: EX writes x5=0xDEADBEEF at t and LSU writes x6=0x12345678 at t. Required at t+1: we_a_o=1, waddr_a_o=5, wdata_a_o=0xDEADBEEF; we_b_o=1, waddr_b_o=6, wdata_b_o=0x12345678. At t+2 both we return to 0.
- APU drain to port B: APU writes x7=0xA5A5A5A5 at t while LSU is idle. Required: we_b_o=1, waddr_b_o=7 at t+2. hazard_o=1 for hazard_raddr_i=7 during t+1 and t+2, and 0 at t+3.
- Full FIFO (DEPTH=2): EX and LSU valid every cycle, APU offers three results. Required: the first two are accepted, apu_ready_o=0 for the third. Once EX goes idle, entries drain through port A one per cycle in push order, and apu_ready_o returns to 1 one cycle after the first pop.
- Address 0: EX and APU each target x0 with data 0xFFFFFFFF. Required: we_a_o stays 0, the APU handshake completes, and apu_fifo_empty_o stays 1.
- Reset mid-operation: FIFO holding 2 entries, then assert rst_n=0. Required: immediately we_a_o=we_b_o=0, apu_ready_o=1, apu_fifo_empty_o=1, hazard_o=0. After release, no stale write appears.
- Pointer wrap: 10 back-to-back APU results with both ports idle. Required: exactly 10 writes to port B, in order, data intact across pointer wrap-around.
